// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel DDS core.
package dds_pkg;

    // Core sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dds_state_e;

    // Bit positions inside the STAT word.
    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_DROPPED  = 2;
    localparam int STAT_OVERFLOW = 3;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = $signed((64'd1 << (w - 1)) - 64'd1);
        lo = -hi - 64'sd1;
        if (v > hi) begin
            saturate = hi;
        end else if (v < lo) begin
            saturate = lo;
        end else begin
            saturate = v;
        end
    endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Synchronous full-wave signed sine ROM, 2^ADDR_W entries, peak 2^(DATA_W-1)-1.
module dds_sine_lut #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                     clk_i,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic signed [DATA_W-1:0] data_o
);

    localparam int  DEPTH = 1 << ADDR_W;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = $itor((1 << (DATA_W - 1)) - 1);

    logic signed [DATA_W-1:0] rom [DEPTH];

    // Table contents are rounded to nearest, half away from zero, at elaboration.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam real R = AMP * $sin(2.0 * PI * $itor(i) / $itor(DEPTH));
        localparam int  V = (R >= 0.0) ? $rtoi(R + 0.5) : -$rtoi(0.5 - R);
        assign rom[i] = DATA_W'(V);
    end

    // Registered read: data appears one cycle after the address.
    always_ff @(posedge clk_i) begin
        data_o <= rom[addr_i];
    end

endmodule

// File: rtl/dds_multich_core.sv
// Multi-channel DDS: per-channel phase accumulators feeding a 3-stage
// LUT / scale / saturating-sum pipeline and a one-entry valid/ready output.
//
// Output handshake: a sample transfers on a cycle where m_valid && m_ready.
// While m_valid && !m_ready, m_data and m_valid hold; the pipeline never
// stalls, so a sample arriving then is discarded and flagged as dropped.
module dds_multich_core
    import dds_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int PHASE_W    = 16,
    parameter int LUT_ADDR_W = 8,
    parameter int OUT_W      = 16,
    parameter int AMPL_W     = 8,
    parameter int DIV_W      = 16,
    parameter int LEN_W      = 16
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESET,
    input  logic                      ctrl_run,
    input  logic                      ctrl_srst,
    input  logic [N_CH*PHASE_W-1:0]   theta_i,
    input  logic [N_CH*PHASE_W-1:0]   delta_i,
    input  logic [N_CH*AMPL_W-1:0]    ampl_i,
    input  logic [DIV_W-1:0]          clkdiv_i,
    input  logic [LEN_W-1:0]          length_i,
    output logic [OUT_W-1:0]          m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [3:0]                stat_o,
    output logic [1:0]                state_o
);

    localparam int SUM_W  = OUT_W + $clog2(N_CH);
    localparam int PROD_W = OUT_W + AMPL_W + 1;

    dds_state_e               state_q, state_d;
    logic                     run_q;
    logic                     len_end_q, len_end_d;
    logic                     cont_q, cont_d;
    logic [DIV_W-1:0]         div_q, div_d, div_last;
    logic [LEN_W-1:0]         remaining_q, remaining_d;
    logic [PHASE_W-1:0]       phase_q [N_CH];
    logic [PHASE_W-1:0]       phase_d [N_CH];
    logic                     tick, start, last_tick, pipe_empty;

    logic signed [OUT_W-1:0]  lut_data [N_CH];
    logic [AMPL_W-1:0]        ampl_s1_q [N_CH];
    logic signed [PROD_W-1:0] prod [N_CH];
    logic signed [OUT_W-1:0]  scaled_d [N_CH];
    logic signed [OUT_W-1:0]  scaled_q [N_CH];
    logic                     v1_q, v2_q;

    logic signed [SUM_W-1:0]  sum;
    logic signed [63:0]       sum_wide, sat_wide;
    logic                     sat_hit;
    logic [OUT_W-1:0]         sat_value;

    logic [OUT_W-1:0]         data_q;
    logic                     valid_q, overflow_q, dropped_q;

    assign pipe_empty = !v1_q && !v2_q && !valid_q;

    // FSM next state, sample tick generation and burst bookkeeping.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        remaining_d = remaining_q;
        cont_d      = cont_q;
        len_end_d   = len_end_q;
        tick        = 1'b0;
        start       = 1'b0;
        last_tick   = 1'b0;
        div_last    = (clkdiv_i == '0) ? '0 : clkdiv_i - DIV_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (ctrl_run && !run_q) begin
                    start       = 1'b1;
                    state_d     = ST_RUN;
                    div_d       = '0;
                    remaining_d = length_i;
                    cont_d      = (length_i == '0);
                    len_end_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // >= rather than == keeps ticking if clkdiv shrinks mid-run.
                if (div_q >= div_last) begin
                    tick  = 1'b1;
                    div_d = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                if (tick && !cont_q) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    last_tick   = (remaining_q == LEN_W'(1));
                end
                if (last_tick) begin
                    state_d   = ST_DRAIN;
                    len_end_d = 1'b1;
                end else if (!ctrl_run) begin
                    state_d   = ST_DRAIN;
                    len_end_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = len_end_q ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!ctrl_run) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase accumulators: load theta on start, advance by delta on each tick.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            phase_d[k] = phase_q[k];
            if (start) begin
                phase_d[k] = theta_i[k*PHASE_W +: PHASE_W];
            end else if (tick) begin
                phase_d[k] = phase_q[k] + delta_i[k*PHASE_W +: PHASE_W];
            end
        end
    end

    // Control state registers with async reset and synchronous soft reset.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            len_end_q   <= 1'b0;
            cont_q      <= 1'b0;
            div_q       <= '0;
            remaining_q <= '0;
            for (int k = 0; k < N_CH; k++) phase_q[k] <= '0;
        end else if (ctrl_srst) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            len_end_q   <= 1'b0;
            cont_q      <= 1'b0;
            div_q       <= '0;
            remaining_q <= '0;
            for (int k = 0; k < N_CH; k++) phase_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= ctrl_run;
            len_end_q   <= len_end_d;
            cont_q      <= cont_d;
            div_q       <= div_d;
            remaining_q <= remaining_d;
            for (int k = 0; k < N_CH; k++) phase_q[k] <= phase_d[k];
        end
    end

    // Stage 1: one ROM per channel, addressed by the pre-update phase.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        dds_sine_lut #(
            .ADDR_W (LUT_ADDR_W),
            .DATA_W (OUT_W)
        ) u_lut (
            .clk_i  (S_AXI_ACLK),
            .addr_i (phase_q[k][PHASE_W-1 -: LUT_ADDR_W]),
            .data_o (lut_data[k])
        );
    end

    // Stage 2 math: signed LUT times unsigned amplitude, floor-shifted back.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            prod[k]     = PROD_W'(lut_data[k]) * PROD_W'($signed({1'b0, ampl_s1_q[k]}));
            scaled_d[k] = OUT_W'(prod[k] >>> AMPL_W);
        end
    end

    // Stage 3 math: widened channel sum, clamped to the output range.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum = sum + SUM_W'(scaled_q[k]);
        end
        sum_wide  = 64'(sum);
        sat_wide  = saturate(sum_wide, OUT_W);
        sat_hit   = (sat_wide != sum_wide);
        sat_value = sat_wide[OUT_W-1:0];
    end

    // Pipeline valids, stage registers, output register and sticky status.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                ampl_s1_q[k] <= '0;
                scaled_q[k]  <= '0;
            end
        end else if (ctrl_srst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                ampl_s1_q[k] <= '0;
                scaled_q[k]  <= '0;
            end
        end else begin
            v1_q <= tick;
            v2_q <= v1_q;
            for (int k = 0; k < N_CH; k++) begin
                if (tick) ampl_s1_q[k] <= ampl_i[k*AMPL_W +: AMPL_W];
                scaled_q[k] <= scaled_d[k];
            end
            if (start) begin
                overflow_q <= 1'b0;
                dropped_q  <= 1'b0;
            end else begin
                if (v2_q && sat_hit) overflow_q <= 1'b1;
                if (v2_q && valid_q && !m_ready) dropped_q <= 1'b1;
            end
            if (!valid_q || m_ready) begin
                valid_q <= v2_q;
                if (v2_q) data_q <= sat_value;
            end
        end
    end

    assign m_data  = data_q;
    assign m_valid = valid_q;
    assign stat_o  = {overflow_q, dropped_q, (state_q == ST_DONE),
                      (state_q == ST_RUN) || (state_q == ST_DRAIN)};
    assign state_o = state_q;

endmodule
